// File: rtl/br_dec_pkg.sv
// Shared types and helpers for the priority grant decoder.
// The build macro BR_DEC_PRIORITY_ORDER_CHECK_EN (used in the top module)
// enables the optional slot-order checking.
package br_dec_pkg;

  // Widest one-hot vector the shared decode helper can produce.
  localparam int unsigned MaxRequesters = 256;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Bits needed to carry an index into n requesters (n >= 2).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // One-hot decode of idx into an n-wide field; all-zero when idx >= n.
  function automatic logic [MaxRequesters-1:0] bin2onehot(input int unsigned idx,
                                                          input int unsigned n);
    logic [MaxRequesters-1:0] oh;
    oh = '0;
    if (idx < n) begin
      oh = MaxRequesters'(1) << idx;
    end
    return oh;
  endfunction

endpackage

// File: rtl/br_dec_priority_grant_decoder_if.sv
// Handshake bundle for the grant decoder: index side in, one-hot side out.
// slave is the decoder's view, master is the view of whoever drives indices
// and consumes grants.
interface br_dec_priority_grant_decoder_if #(
  parameter int unsigned NumRequesters = 4,
  parameter int unsigned NumResults    = 1
);
  localparam int unsigned IndexWidth = br_dec_pkg::idx_width(NumRequesters);

  logic                                         in_valid;
  logic                                         in_ready;
  logic [NumResults*IndexWidth-1:0]             in_idx;
  logic [NumResults-1:0]                        in_idx_valid;
  logic                                         out_valid;
  logic                                         out_ready;
  logic [NumResults-1:0][NumRequesters-1:0]     out;
  logic [NumRequesters-1:0]                     out_union;

  modport slave (
    input  in_valid, in_idx, in_idx_valid, out_ready,
    output in_ready, out_valid, out, out_union
  );

  modport master (
    output in_valid, in_idx, in_idx_valid, out_ready,
    input  in_ready, out_valid, out, out_union
  );

endinterface

// File: rtl/br_dec_bin2onehot.sv
// Combinational binary-to-one-hot decode of a single index, with a flag for
// indices that fall outside the requester range (possible when the requester
// count is not a power of two).
module br_dec_bin2onehot
  import br_dec_pkg::*;
#(
  parameter int unsigned NumRequesters = 4,
  parameter int unsigned IndexWidth    = idx_width(NumRequesters)
) (
  input  logic [IndexWidth-1:0]    idx,
  output logic [NumRequesters-1:0] onehot,
  output logic                     out_of_range
);

  assign onehot       = NumRequesters'(bin2onehot(32'(idx), NumRequesters));
  assign out_of_range = (32'(idx) >= NumRequesters);

endmodule

// File: rtl/br_dec_priority_grant_decoder.sv
// Priority grant decoder: rebuilds per-slot one-hot grant vectors and their
// union from binary indices, buffered through a two-entry FIFO so in_ready
// can be registered without losing throughput. Sticky flags report
// out-of-range and duplicate indices.
// Optional macro BR_DEC_PRIORITY_ORDER_CHECK_EN adds err_order, which flags
// slot patterns that are not a valid-prefix with strictly increasing indices.
module br_dec_priority_grant_decoder
  import br_dec_pkg::*;
#(
  parameter int unsigned NumRequesters = 4,
  parameter int unsigned NumResults    = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  br_dec_priority_grant_decoder_if.slave   bus,
  input  logic                             err_clear,
  output logic                             err_range,
  output logic                             err_dup
`ifdef BR_DEC_PRIORITY_ORDER_CHECK_EN
  ,
  output logic                             err_order
`endif
);

  localparam int unsigned IndexWidth = idx_width(NumRequesters);

  typedef logic [NumResults-1:0][NumRequesters-1:0] rows_t;
  typedef logic [NumRequesters-1:0]                 vec_t;

  // ---------------- input-side decode ----------------
  logic [NumResults-1:0][IndexWidth-1:0]    slot_idx;
  logic [NumResults-1:0][NumRequesters-1:0] slot_onehot;
  logic [NumResults-1:0]                    slot_oor;
  rows_t                                    dec_rows;
  logic [NumRequesters-1:0][NumResults-1:0] dec_cols;
  vec_t                                     dec_union;
  logic [NumResults-1:0][NumResults-1:0]    dup_pair;
  logic                                     range_hit;
  logic                                     dup_hit;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NumResults; gi++) begin : g_slot
      assign slot_idx[gi] = bus.in_idx[gi*IndexWidth +: IndexWidth];

      br_dec_bin2onehot #(
        .NumRequesters (NumRequesters),
        .IndexWidth    (IndexWidth)
      ) u_dec (
        .idx          (slot_idx[gi]),
        .onehot       (slot_onehot[gi]),
        .out_of_range (slot_oor[gi])
      );

      // Invalid slots decode to an all-zero row; out-of-range already does.
      assign dec_rows[gi] = bus.in_idx_valid[gi] ? slot_onehot[gi] : '0;

      // Pairwise duplicate detection over the upper triangle only.
      for (gj = 0; gj < NumResults; gj++) begin : g_pair
        if (gj > gi) begin : g_cmp
          assign dup_pair[gi][gj] = bus.in_idx_valid[gi] & bus.in_idx_valid[gj] &
                                    (slot_idx[gi] == slot_idx[gj]);
        end else begin : g_zero
          assign dup_pair[gi][gj] = 1'b0;
        end
      end
    end

    // Union is built column-wise so each requester bit is an OR over slots.
    for (gi = 0; gi < NumRequesters; gi++) begin : g_col
      for (gj = 0; gj < NumResults; gj++) begin : g_row
        assign dec_cols[gi][gj] = dec_rows[gj][gi];
      end
      assign dec_union[gi] = |dec_cols[gi];
    end
  endgenerate

  assign range_hit = |(bus.in_idx_valid & slot_oor);
  assign dup_hit   = |dup_pair;

`ifdef BR_DEC_PRIORITY_ORDER_CHECK_EN
  // A hole in the valid pattern or a non-increasing neighbour is an order fault;
  // with a clean prefix, checking adjacent slots is enough for strict order.
  logic [NumResults-1:0] order_bad_vec;
  logic                  order_bad;
  assign order_bad_vec[0] = 1'b0;
  generate
    for (gi = 1; gi < NumResults; gi++) begin : g_order
      assign order_bad_vec[gi] =
          (bus.in_idx_valid[gi] & ~bus.in_idx_valid[gi-1]) |
          (bus.in_idx_valid[gi] & bus.in_idx_valid[gi-1] &
           (slot_idx[gi] <= slot_idx[gi-1]));
    end
  endgenerate
  assign order_bad = |order_bad_vec;
`endif

  // ---------------- two-entry buffer ----------------
  buf_state_e state_q, state_d;
  logic       in_ready_q, in_ready_d;
  rows_t      head_rows_q, head_rows_d, tail_rows_q, tail_rows_d;
  vec_t       head_union_q, head_union_d, tail_union_q, tail_union_d;
  logic       in_acc, out_acc;

  assign in_acc  = bus.in_valid & in_ready_q;
  assign out_acc = (state_q != BUF_EMPTY) & bus.out_ready;

  // Next occupancy and entry movement; head always holds the oldest entry.
  always_comb begin
    state_d      = state_q;
    head_rows_d  = head_rows_q;
    head_union_d = head_union_q;
    tail_rows_d  = tail_rows_q;
    tail_union_d = tail_union_q;
    case (state_q)
      BUF_EMPTY: begin
        if (in_acc) begin
          state_d      = BUF_ONE;
          head_rows_d  = dec_rows;
          head_union_d = dec_union;
        end
      end
      BUF_ONE: begin
        if (in_acc && out_acc) begin
          head_rows_d  = dec_rows;
          head_union_d = dec_union;
        end else if (in_acc) begin
          state_d      = BUF_TWO;
          tail_rows_d  = dec_rows;
          tail_union_d = dec_union;
        end else if (out_acc) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (out_acc) begin
          state_d      = BUF_ONE;
          head_rows_d  = tail_rows_q;
          head_union_d = tail_union_q;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    in_ready_d = (state_d != BUF_TWO);
  end

  // Buffer state and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BUF_EMPTY;
      in_ready_q   <= 1'b0;
      head_rows_q  <= '0;
      head_union_q <= '0;
      tail_rows_q  <= '0;
      tail_union_q <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      head_rows_q  <= head_rows_d;
      head_union_q <= head_union_d;
      tail_rows_q  <= tail_rows_d;
      tail_union_q <= tail_union_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != BUF_EMPTY);
  assign bus.out       = head_rows_q;
  assign bus.out_union = head_union_q;

  // ---------------- sticky error flags ----------------
  logic err_range_q, err_dup_q;

  // Flags set on an accepted faulty transfer; a same-cycle set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_range_q <= 1'b0;
      err_dup_q   <= 1'b0;
    end else begin
      err_range_q <= (in_acc & range_hit) | (err_range_q & ~err_clear);
      err_dup_q   <= (in_acc & dup_hit)   | (err_dup_q & ~err_clear);
    end
  end

  assign err_range = err_range_q;
  assign err_dup   = err_dup_q;

`ifdef BR_DEC_PRIORITY_ORDER_CHECK_EN
  logic err_order_q;

  // Order flag follows the same set-beats-clear rule as the other flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_order_q <= 1'b0;
    end else begin
      err_order_q <= (in_acc & order_bad) | (err_order_q & ~err_clear);
    end
  end

  assign err_order = err_order_q;

  a_order_flag: assert property (@(posedge clk) disable iff (!rst_n)
                                 (in_acc && order_bad) |=> err_order_q);
`endif

  a_in_valid_known: assert property (@(posedge clk) disable iff (!rst_n)
                                     !$isunknown(bus.in_valid));

endmodule
